dmem_byte_ctrl: RTL
===================

Name: dmem_byte_ctrl

Overview:
Parametrised data memory for the unprivileged RISC-V core's load/store unit. It replaces the flat word-only RAM with a valid/ready request channel and a fixed-latency response channel. It supports byte, half and word access with per-byte write enables and sign- or zero-extension on loads. It flags misaligned and out-of-range accesses instead of silently aliasing them.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, >= 4.
LATENCY, 1, cycles spent in ACCESS state; must be >= 1.
INIT_FILE, "", optional hex image loaded at elaboration; empty means contents are undefined.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal (funct3[1:0] encoding).
req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
req_wdata  input  32  store data, right-justified (LSBs hold the value).
rsp_valid  output  1  one-cycle response pulse, for both loads and stores.
rsp_rdata  output  32  extended load data; 0 for stores and for errors.
rsp_err  output  1  misaligned, out-of-range or illegal-size access; valid with rsp_valid.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0. RAM contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready at an edge, latch we/addr/size/unsigned/wdata, load counter with LATENCY-1, go to ACCESS.
  - ACCESS: req_ready=0. The counter decrements each edge. At the edge where the counter is 0, perform the array access (write or read) and go to RESP.
  - RESP: rsp_valid=1 for exactly this cycle; rsp_rdata and rsp_err are held stable. Next edge returns to IDLE. Requests are not accepted during RESP.
- Timing: request accepted at edge E0 gives rsp_valid high in the cycle after edge E(LATENCY). Back-to-back throughput is one request per LATENCY+2 cycles.
- Error detection (combinational on latched request):
  - size=1 with addr[0]=1 is misaligned.
  - size=2 with addr[1:0]!=0 is misaligned.
  - size=3 is illegal.
  - Any of addr[31:log2(DEPTH_WORDS)+2] nonzero is out of range.
  - On error: no array write occurs, rsp_rdata=0, rsp_err=1, and latency is unchanged.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Stores:
  - Byte-enable mask is 0001<<lane for byte, 0011<<lane for half, 1111 for word.
  - Write data is req_wdata shifted left by 8*lane.
  - Unenabled bytes of the word are preserved.
- Loads:
  - Extract the selected byte or half by shifting right 8*lane.
  - Sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned. Word loads ignore req_unsigned.
- Store followed by load to the same word returns the updated data; no bypass is needed because accesses are serialised.
- Reset asserted mid-ACCESS: the request is abandoned. If reset lands before the access edge, no write occurs. No response is issued.
- req_valid deasserted before acceptance is legal; nothing is latched.
- Changes on req_* while in ACCESS or RESP are ignored.

Decomposition:
- Package dmem_pkg holds:
  - SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2;
  - state encoding IDLE/ACCESS/RESP;
  - function to compute index width from DEPTH_WORDS.
- Sub-module dmem_lane_align (combinational) takes size, lane, unsigned, wdata and raw read word. It produces the 4-bit byte-enable, shifted write data and extended load data. It is verified standalone.
- The top holds the FSM, the counter, the request latch, error detection and the RAM array with byte-enable write.

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word 0x10 (LATENCY=1). Required: rsp_rdata=0xDEADBEEF, rsp_err=0, and rsp_valid exactly 2 cycles after each accept edge.
- Store byte 0x7F to 0x13, then load word 0x10. Required: 0x7FADBEEF. Then LB 0x11 gives 0xFFFFFFBE, and LBU 0x11 gives 0x000000BE.
- Store half 0x8001 to 0x22, then LH 0x22 gives 0xFFFF8001 and LHU 0x22 gives 0x00008001. A word load of 0x20 shows only bytes 2-3 changed.
- LW 0x12, SH 0x21, size=3, and SW 0x1000 with DEPTH_WORDS=1024: each gives rsp_err=1 and rsp_rdata=0. A subsequent load shows memory unchanged.
- LATENCY=3: req_ready=0 and busy=1 for 4 cycles after accept. req_valid held high is accepted again only once back in IDLE.
- SW issued, then rst_n pulsed low during ACCESS. Required: no rsp_valid, all outputs at reset values, and a later load of that word shows the old data.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the byte-addressable data memory.
//   - access size encodings (funct3[1:0] of RISC-V loads/stores)
//   - controller state encoding
//   - helper to derive the word-index width from the memory depth
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Number of word-index bits needed to address depth_words 32-bit words.
  function automatic int idx_width(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering for a 32-bit
// little-endian memory word.
// Ports:
//   size          in  2   access size (byte/half/word, 3 = illegal)
//   lane          in  2   byte offset within the word (addr[1:0])
//   load_unsigned in  1   1 = zero-extend loads, 0 = sign-extend
//   wdata         in  32  right-justified store data
//   rdata_raw     in  32  raw word read from the array
//   byte_en       out 4   per-byte write enable (0 for illegal size)
//   wdata_sh      out 32  store data moved into its byte lanes
//   rdata_ext     out 32  selected byte/half/word, extended to 32 bits
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [4:0]  shamt_s;
  logic [31:0] rd_shift_s;

  // Shift amount in bits is 8*lane.
  assign shamt_s = {lane, 3'b000};

  // Lane steering for stores and extraction/extension for loads.
  always_comb begin
    wdata_sh   = wdata << shamt_s;
    rd_shift_s = rdata_raw >> shamt_s;
    byte_en    = 4'b0000;
    rdata_ext  = 32'h0000_0000;
    case (size)
      SIZE_BYTE: begin
        byte_en = 4'b0001 << lane;
        if (load_unsigned) begin
          rdata_ext = {24'h00_0000, rd_shift_s[7:0]};
        end else begin
          rdata_ext = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
        end
      end
      SIZE_HALF: begin
        // lane 3 would spill out of the word; the top flags it as misaligned.
        byte_en = 4'b0011 << lane;
        if (load_unsigned) begin
          rdata_ext = {16'h0000, rd_shift_s[15:0]};
        end else begin
          rdata_ext = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
        end
      end
      SIZE_WORD: begin
        byte_en   = 4'b1111;
        rdata_ext = rd_shift_s;
      end
      default: begin
        byte_en   = 4'b0000;
        rdata_ext = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_byte_ctrl.sv
// dmem_byte_ctrl: data memory for the load/store unit with a valid/ready
// request channel and a fixed-latency, single-cycle response pulse.
// Byte/half/word accesses, per-byte write enables, sign/zero-extended loads,
// and error reporting for misaligned, out-of-range and illegal-size requests.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   LATENCY      cycles spent in ACCESS (>= 1)
//   INIT_FILE    optional hex image name; contents are left undefined
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (accepted only in IDLE)
//   req_we              1 = store, 0 = load
//   req_addr            byte address
//   req_size            0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata           right-justified store data
//   rsp_valid           one-cycle response pulse (loads and stores)
//   rsp_rdata           extended load data; 0 for stores and errors
//   rsp_err             access error, valid with rsp_valid
//   busy                high whenever the controller is not IDLE
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Latched request
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [1:0]     size_q, size_d;
  logic           uns_q, uns_d;
  logic [31:0]    wdata_q, wdata_d;

  // Registered outputs
  logic           req_ready_q, req_ready_d;
  logic           busy_q, busy_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic [31:0]    mem [DEPTH_WORDS];

  logic [IW-1:0]  idx_s;
  logic [1:0]     lane_s;
  logic           misalign_s;
  logic           illegal_s;
  logic           oor_s;
  logic           err_s;
  logic           mem_we_s;
  logic [31:0]    rdata_raw_s;
  logic [3:0]     byte_en_s;
  logic [31:0]    wdata_sh_s;
  logic [31:0]    rdata_ext_s;

  assign idx_s       = addr_q[IW+1:2];
  assign lane_s      = addr_q[1:0];
  assign rdata_raw_s = mem[idx_s];

  // Error classification of the latched request.
  always_comb begin
    misalign_s = 1'b0;
    illegal_s  = 1'b0;
    case (size_q)
      SIZE_BYTE: misalign_s = 1'b0;
      SIZE_HALF: misalign_s = addr_q[0];
      SIZE_WORD: misalign_s = (addr_q[1:0] != 2'b00);
      default:   illegal_s  = 1'b1;
    endcase
    // Any address bit above the array's byte range means the access would alias.
    oor_s = (addr_q[31:IW+2] != '0);
    err_s = misalign_s | illegal_s | oor_s;
  end

  dmem_lane_align u_lane_align (
    .size          (size_q),
    .lane          (lane_s),
    .load_unsigned (uns_q),
    .wdata         (wdata_q),
    .rdata_raw     (rdata_raw_s),
    .byte_en       (byte_en_s),
    .wdata_sh      (wdata_sh_s),
    .rdata_ext     (rdata_ext_s)
  );

  // Next-state, request latch, counter and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Array access edge: write (if legal) and capture the response.
          mem_we_s    = we_q & ~err_s;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_s;
          if (err_s || we_q) begin
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            rsp_rdata_d = rdata_ext_s;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake/status outputs are registered copies of the next state.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // Controller state, request latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      size_q      <= SIZE_BYTE;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled array write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_s[b]) begin
          mem[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
